// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-port synchronous BRAM between two requesters (A and B).
// Each requester issues read/write commands on a valid/ready handshake. At most
// one command is granted per cycle. The granted command is presented to the
// BRAM on registered outputs in the next cycle. Read data comes back on the
// requesting port two cycles after the handshake.
//
// Optional feature:
//   BRAM_ARB_RR_EN  When defined, ties are broken round-robin using a 1-bit
//                   last-grant register. When undefined, port A always wins a
//                   tie, so B can starve under a continuous A stream.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   a_valid/a_ready             port A command handshake
//   a_we, a_addr, a_wdata       port A command (1 = write, 0 = read)
//   a_rvalid, a_rdata           port A read response (one-cycle pulse)
//   b_*                         port B, same meaning as port A
//   mem_we, mem_addr, mem_din   registered drive into the BRAM
//   mem_dout                    BRAM read data, valid one cycle after addr
// -----------------------------------------------------------------------------
module bram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  any_grant_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_din_r;

    // First tag stage: travels alongside the registered BRAM command.
    logic                  tag_valid_r;
    logic                  tag_read_r;
    logic                  tag_port_r;   // 0 = A, 1 = B

    // Second tag stage is decoded straight into per-port rvalid registers.
    logic                  a_rvalid_r;
    logic                  b_rvalid_r;

`ifdef BRAM_ARB_RR_EN
    logic                  last_grant_r; // 0 = A granted last, 1 = B granted last
`endif

    // Arbitration: pick at most one port. Reset blocks all grants.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (reset) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
`ifdef BRAM_ARB_RR_EN
            if (a_valid && b_valid) begin
                // Tie: favour whichever port was not granted most recently.
                if (last_grant_r) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
`else
            grant_a_s = a_valid;
            grant_b_s = b_valid && !a_valid;
`endif
        end
    end

    assign a_ready     = grant_a_s;
    assign b_ready     = grant_b_s;
    assign any_grant_s = grant_a_s || grant_b_s;

    // Command mux: B's fields only when B holds the grant.
    always_comb begin
        sel_we_s    = a_we;
        sel_addr_s  = a_addr;
        sel_wdata_s = a_wdata;
        if (grant_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // BRAM drive registers and response tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_din_r   <= {DATA_WIDTH{1'b0}};
            tag_valid_r <= 1'b0;
            tag_read_r  <= 1'b0;
            tag_port_r  <= 1'b0;
            a_rvalid_r  <= 1'b0;
            b_rvalid_r  <= 1'b0;
        end else begin
            mem_we_r <= any_grant_s && sel_we_s;
            // Address and write data hold their last value while idle; write
            // data only changes on a write since reads never use it.
            if (any_grant_s) begin
                mem_addr_r <= sel_addr_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (any_grant_s && sel_we_s) begin
                mem_din_r <= sel_wdata_s;
            end else begin
                mem_din_r <= mem_din_r;
            end
            tag_valid_r <= any_grant_s;
            tag_read_r  <= !sel_we_s;
            tag_port_r  <= grant_b_s;
            a_rvalid_r  <= tag_valid_r && tag_read_r && !tag_port_r;
            b_rvalid_r  <= tag_valid_r && tag_read_r && tag_port_r;
        end
    end

`ifdef BRAM_ARB_RR_EN
    // Round-robin pointer: reset value 1 makes port A preferred first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (any_grant_s) begin
            last_grant_r <= grant_b_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign mem_we   = mem_we_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;
    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;

    // BRAM dout is only valid in the response cycle, so it cannot be
    // registered here; gating keeps rdata at zero outside a response.
    assign a_rdata  = a_rvalid_r ? mem_dout : {DATA_WIDTH{1'b0}};
    assign b_rdata  = b_rvalid_r ? mem_dout : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//
// Self-checking bench for bram_arbiter. Includes a behavioural single-port
// BRAM, preloaded with 0x10,0x20,0x30,0x40 at words 0..3. A reference model
// predicts grants, BRAM drive values and read responses (memory array plus a
// response queue with due cycles). The bench runs directed steps, then a
// randomized stream with occasional resets. Define BRAM_ARB_RR_EN consistently
// for both the RTL and this bench.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          preload;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Behavioural single-port BRAM with an init image.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) begin
                bram[i] <= (i < 4) ? DW'(16 * (i + 1)) : {DW{1'b0}};
            end
        end else begin
            if (mem_we) bram[mem_addr] <= mem_din;
            mem_dout <= bram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } resp_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    resp_t         sbq[$];
    bit            lg_b;        // model: B was granted most recently
    bit            rst_prev;    // reset was sampled at the previous edge
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    bit            ga, gb;      // model grants of the last tick
    int            cyc;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: check everything mid-cycle, advance the model,
    // then step past the rising edge.
    task automatic tick();
        bit            ea, eb;
        logic [DW-1:0] ed;
        resp_t         r;
        @(negedge clk);
        ga = 1'b0;
        gb = 1'b0;
        if (!reset) begin
            if (a_valid && b_valid) begin
`ifdef BRAM_ARB_RR_EN
                ga = lg_b;
                gb = !lg_b;
`else
                ga = 1'b1;
`endif
            end else begin
                ga = a_valid;
                gb = b_valid;
            end
        end
        chk("a_ready", DW'(a_ready), DW'(ga));
        chk("b_ready", DW'(b_ready), DW'(gb));

        ea = 1'b0;
        eb = 1'b0;
        ed = {DW{1'b0}};
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            r  = sbq.pop_front();
            ea = !r.port;
            eb = r.port;
            ed = r.data;
        end
        chk("a_rvalid", DW'(a_rvalid), DW'(ea));
        chk("b_rvalid", DW'(b_rvalid), DW'(eb));
        if (ea) chk("a_rdata", a_rdata, ed);
        if (eb) chk("b_rdata", b_rdata, ed);
        if (rst_prev) begin
            chk("a_rdata_rst", a_rdata, {DW{1'b0}});
            chk("b_rdata_rst", b_rdata, {DW{1'b0}});
        end
        chk("mem_we", DW'(mem_we), DW'(exp_we));
        chk("mem_addr", DW'(mem_addr), DW'(exp_addr));
        chk("mem_din", mem_din, exp_din);

        if (reset) begin
            sbq.delete();
            exp_we   = 1'b0;
            exp_addr = {AW{1'b0}};
            exp_din  = {DW{1'b0}};
            lg_b     = 1'b1;
        end else if (ga || gb) begin
            logic          cwe;
            logic [AW-1:0] cad;
            logic [DW-1:0] cwd;
            cwe = ga ? a_we : b_we;
            cad = ga ? a_addr : b_addr;
            cwd = ga ? a_wdata : b_wdata;
            exp_we   = cwe;
            exp_addr = cad;
            lg_b     = gb;
            if (cwe) begin
                exp_din      = cwd;
                ref_mem[cad] = cwd;
            end else begin
                r.due  = cyc + 2;
                r.port = gb;
                r.data = ref_mem[cad];
                sbq.push_back(r);
            end
        end else begin
            exp_we = 1'b0;
        end
        rst_prev = reset;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] ad;
        if ($urandom_range(0, 4) == 0) ad = {AW{1'b1}};
        else ad = AW'($urandom_range(0, 7));
        return ad;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = {DW{1'b0}};
        ref_mem[0] = 32'h0000_0010;
        ref_mem[1] = 32'h0000_0020;
        ref_mem[2] = 32'h0000_0030;
        ref_mem[3] = 32'h0000_0040;
        lg_b     = 1'b1;
        rst_prev = 1'b1;
        exp_we   = 1'b0;
        exp_addr = {AW{1'b0}};
        exp_din  = {DW{1'b0}};

        // First edge: reset the DUT and load the BRAM image.
        reset   = 1'b1;
        preload = 1'b1;
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset held three cycles with both valids high.
        set_a(1'b1, 1'b0, 13'h001, {DW{1'b0}});
        set_b(1'b1, 1'b1, 13'h002, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        tick();

        // Single write then read on A.
        set_a(1'b1, 1'b1, 13'h005, 32'hDEAD_BEEF);
        tick();
        set_a(1'b1, 1'b0, 13'h005, {DW{1'b0}});
        tick();
        set_a(1'b0, 1'b0, 13'h005, {DW{1'b0}});
        for (int i = 0; i < 3; i++) tick();

        // Back-to-back B reads of the init image.
        for (int i = 0; i < 4; i++) begin
            set_b(1'b1, 1'b0, AW'(i), {DW{1'b0}});
            tick();
        end
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        for (int i = 0; i < 3; i++) tick();

        // Contention: both valid for six cycles.
        set_a(1'b1, 1'b0, 13'h001, {DW{1'b0}});
        set_b(1'b1, 1'b0, 13'h002, {DW{1'b0}});
        for (int i = 0; i < 6; i++) tick();
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        for (int i = 0; i < 3; i++) tick();

        // Write on A at the top address, read it from B the next cycle.
        set_a(1'b1, 1'b1, 13'h1FFF, 32'h1234_5678);
        tick();
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        set_b(1'b1, 1'b0, 13'h1FFF, {DW{1'b0}});
        tick();
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        for (int i = 0; i < 3; i++) tick();

        // Reset the cycle after an A read handshake.
        set_a(1'b1, 1'b0, 13'h005, {DW{1'b0}});
        tick();
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_a(1'b1, 1'b0, 13'h005, {DW{1'b0}});
        tick();
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic; a requester holds its command until accepted.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            tick();
            if (!a_valid || ga) begin
                if ($urandom_range(0, 3) != 0)
                    set_a(1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom()));
                else
                    set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
            end
            if (!b_valid || gb) begin
                if ($urandom_range(0, 3) != 0)
                    set_b(1'b1, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom()));
                else
                    set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
            end
        end
        reset = 1'b0;
        set_a(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        set_b(1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}});
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
